// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step/breakpoint sequencer issuing the CPU datapath clock enable
// Optional feature: define CPU_RUN_CTRL_BP_EN to compile in breakpoint compare, bp_skip and BREAK.
module cpu_run_ctrl #(
  parameter int CYC_W = 32,
  parameter int BP_W  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             bp_en,
  input  logic [BP_W-1:0]  bp_addr,
  input  logic [BP_W-1:0]  pc,
  output logic             cpu_ce,
  output logic [2:0]       state,
  output logic             halted,
  output logic [1:0]       stop_cause,
  output logic [CYC_W-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_BREAK = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t cur;
  logic   step_q;
  logic   step_rise;
  logic   bp_hit;

  assign step_rise = step & ~step_q;

`ifdef CPU_RUN_CTRL_BP_EN
  logic bp_skip;
  // bp_skip lets a resumed run execute the instruction it was parked on
  assign bp_hit = bp_en & (pc == bp_addr) & ~bp_skip;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_addr, pc};
  assign bp_hit    = 1'b0;
`endif

  always_comb begin
    cpu_ce = 1'b0;
    case (cur)
      S_RUN:   cpu_ce = ~halt_req & ~bp_hit;
      S_STEP:  cpu_ce = ~halt_req;
      default: cpu_ce = 1'b0;
    endcase
  end

  assign state  = cur;
  assign halted = (cur == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= S_IDLE;
      step_q     <= 1'b0;
      stop_cause <= 2'd0;
      cycle_cnt  <= '0;
`ifdef CPU_RUN_CTRL_BP_EN
      bp_skip    <= 1'b0;
`endif
    end else begin
      step_q <= step;
      if (cpu_ce && (cycle_cnt != {CYC_W{1'b1}}))
        cycle_cnt <= cycle_cnt + CYC_W'(1);

      case (cur)
        S_IDLE: begin
          if (run) begin
            cur        <= S_RUN;
            stop_cause <= 2'd0;
`ifdef CPU_RUN_CTRL_BP_EN
            bp_skip    <= 1'b1;
`endif
          end else if (step_rise) begin
            cur <= S_STEP;
          end
        end
        S_RUN: begin
`ifdef CPU_RUN_CTRL_BP_EN
          bp_skip <= 1'b0;
`endif
          if (halt_req) begin
            cur        <= S_HALT;
            stop_cause <= 2'd2;
          end else if (bp_hit) begin
            cur        <= S_BREAK;
            stop_cause <= 2'd3;
          end else if (!run) begin
            cur        <= S_IDLE;
            stop_cause <= 2'd1;
          end
        end
        S_STEP: begin
          if (halt_req) begin
            cur        <= S_HALT;
            stop_cause <= 2'd2;
          end else begin
            cur        <= S_IDLE;
            stop_cause <= 2'd1;
          end
        end
        S_BREAK: begin
          if (!run)
            cur <= S_IDLE;
          else if (step_rise)
            cur <= S_STEP;
        end
        S_HALT:  cur <= S_HALT;
        default: cur <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - scoreboard bench for cpu_run_ctrl (default and 4-bit counter instances)
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, run, step, halt_req, bp_en;
  logic [11:0] bp_addr, pc;
  logic        cpu_ce, halted, sat_ce, sat_halted;
  logic [2:0]  state, sat_state;
  logic [1:0]  stop_cause, sat_cause;
  logic [31:0] cycle_cnt;
  logic [3:0]  sat_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic ce_q[$];
  logic mon_exp;

  cpu_run_ctrl #(.CYC_W(32), .BP_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halt_req(halt_req),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_ce(cpu_ce), .state(state),
    .halted(halted), .stop_cause(stop_cause), .cycle_cnt(cycle_cnt)
  );

  cpu_run_ctrl #(.CYC_W(4), .BP_W(12)) dut_sat (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halt_req(halt_req),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_ce(sat_ce), .state(sat_state),
    .halted(sat_halted), .stop_cause(sat_cause), .cycle_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  // CPU program counter: advances one word per enabled cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 12'h000;
    else if (cpu_ce) pc <= pc + 12'd4;
  end

  always @(negedge clk) begin
    if (ce_q.size() > 0) begin
      mon_exp = ce_q.pop_front();
      n_checks++;
      if (cpu_ce !== mon_exp) begin
        n_fail++;
        $display("FAIL cpu_ce t=%0t state=%0d pc=%h got=%b exp=%b", $time, state, pc, cpu_ce, mon_exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic cyc(input logic r, input logic s, input logic h, input logic exp_ce);
    run = r; step = s; halt_req = h;
    ce_q.push_back(exp_ce);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0; bp_en = 1'b0; bp_addr = 12'h000;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; step = 1'b0; halt_req = 1'b0; bp_en = 1'b0; bp_addr = 12'h000;
    #1;
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_checks++; if (cpu_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce got=%b exp=0", cpu_ce); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b exp=0", halted); end
    n_checks++; if (stop_cause !== 2'd0) begin n_fail++; $display("FAIL reset_cause got=%0d exp=0", stop_cause); end
    n_checks++; if (cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cycle_cnt); end
    n_checks++; if (sat_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_sat_cnt got=%0d exp=0", sat_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1; run = 1'b0;
  endtask

  task automatic test_run();
    apply_reset();
    cyc(1, 0, 0, 0);
    n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL run_enter got=%0d exp=1", state); end
    repeat (4) cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL run_state got=%0d exp=0", state); end
    n_checks++; if (cycle_cnt !== 32'd5) begin n_fail++; $display("FAIL run_cnt got=%0d exp=5", cycle_cnt); end
    n_checks++; if (stop_cause !== 2'd1) begin n_fail++; $display("FAIL run_cause got=%0d exp=1", stop_cause); end
  endtask

  task automatic test_step();
    apply_reset();
    cyc(0, 1, 0, 0);
    n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL step_enter got=%0d exp=2", state); end
    cyc(0, 1, 0, 1);
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL step_exit got=%0d exp=0", state); end
    n_checks++; if (stop_cause !== 2'd1) begin n_fail++; $display("FAIL step_cause got=%0d exp=1", stop_cause); end
    repeat (8) cyc(0, 1, 0, 0);
    n_checks++; if (cycle_cnt !== 32'd1) begin n_fail++; $display("FAIL step_held_cnt got=%0d exp=1", cycle_cnt); end
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    n_checks++; if (cycle_cnt !== 32'd2) begin n_fail++; $display("FAIL step_second_cnt got=%0d exp=2", cycle_cnt); end
  endtask

`ifdef CPU_RUN_CTRL_BP_EN
  task automatic test_breakpoint();
    apply_reset();
    bp_en = 1'b1; bp_addr = 12'h010;
    cyc(1, 0, 0, 0);
    repeat (4) cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL bp_state got=%0d exp=3", state); end
    n_checks++; if (pc !== 12'h010) begin n_fail++; $display("FAIL bp_pc got=%h exp=010", pc); end
    n_checks++; if (cycle_cnt !== 32'd4) begin n_fail++; $display("FAIL bp_cnt got=%0d exp=4", cycle_cnt); end
    n_checks++; if (stop_cause !== 2'd3) begin n_fail++; $display("FAIL bp_cause got=%0d exp=3", stop_cause); end
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    n_checks++; if (stop_cause !== 2'd3) begin n_fail++; $display("FAIL bp_idle_cause got=%0d exp=3", stop_cause); end
    cyc(1, 0, 0, 0);
    n_checks++; if (stop_cause !== 2'd0) begin n_fail++; $display("FAIL resume_cause got=%0d exp=0", stop_cause); end
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL resume_state got=%0d exp=1", state); end
    n_checks++; if (cycle_cnt !== 32'd6) begin n_fail++; $display("FAIL resume_cnt got=%0d exp=6", cycle_cnt); end
    bp_addr = 12'h020;
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL bp_step_state got=%0d exp=2", state); end
    cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 0);
    n_checks++; if (cycle_cnt !== 32'd9) begin n_fail++; $display("FAIL bp_step_cnt got=%0d exp=9", cycle_cnt); end
    n_checks++; if (pc !== 12'h024) begin n_fail++; $display("FAIL bp_step_pc got=%h exp=024", pc); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    bp_en = 1'b1; bp_addr = 12'h008;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 1, 0);
    n_checks++; if (state !== 3'd4) begin n_fail++; $display("FAIL simul_state got=%0d exp=4", state); end
    n_checks++; if (stop_cause !== 2'd2) begin n_fail++; $display("FAIL simul_cause got=%0d exp=2", stop_cause); end
  endtask
`else
  task automatic test_no_break();
    apply_reset();
    bp_en = 1'b1; bp_addr = 12'h010;
    cyc(1, 0, 0, 0);
    repeat (8) cyc(1, 0, 0, 1);
    n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL nobp_state got=%0d exp=1", state); end
    n_checks++; if (cycle_cnt !== 32'd8) begin n_fail++; $display("FAIL nobp_cnt got=%0d exp=8", cycle_cnt); end
    n_checks++; if (pc !== 12'h020) begin n_fail++; $display("FAIL nobp_pc got=%h exp=020", pc); end
    cyc(0, 0, 0, 1);
    n_checks++; if (stop_cause !== 2'd1) begin n_fail++; $display("FAIL nobp_cause got=%0d exp=1", stop_cause); end
  endtask
`endif

  task automatic test_halt();
    apply_reset();
    cyc(1, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 1);
    cyc(1, 0, 1, 0);
    n_checks++; if (state !== 3'd4) begin n_fail++; $display("FAIL halt_state got=%0d exp=4", state); end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag got=%b exp=1", halted); end
    n_checks++; if (stop_cause !== 2'd2) begin n_fail++; $display("FAIL halt_cause got=%0d exp=2", stop_cause); end
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    n_checks++; if (state !== 3'd4) begin n_fail++; $display("FAIL halt_absorb got=%0d exp=4", state); end
    n_checks++; if (cycle_cnt !== 32'd3) begin n_fail++; $display("FAIL halt_cnt got=%0d exp=3", cycle_cnt); end
    rst_n = 1'b0; run = 1'b0; step = 1'b0;
    #1;
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL halt_rst_state got=%0d exp=0", state); end
    n_checks++; if (cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL halt_rst_cnt got=%0d exp=0", cycle_cnt); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_rst_flag got=%b exp=0", halted); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    n_checks++; if (cpu_ce !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_ce got=%b exp=1", cpu_ce); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (cpu_ce !== 1'b0) begin n_fail++; $display("FAIL midrst_ce got=%b exp=0", cpu_ce); end
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL midrst_state got=%0d exp=0", state); end
    @(posedge clk); #1;
    rst_n = 1'b1; run = 1'b0;
  endtask

  task automatic test_saturate();
    apply_reset();
    cyc(1, 0, 0, 0);
    repeat (15) cyc(1, 0, 0, 1);
    n_checks++; if (sat_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_at15 got=%0d exp=15", sat_cnt); end
    repeat (5) cyc(1, 0, 0, 1);
    n_checks++; if (sat_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold got=%0d exp=15", sat_cnt); end
    n_checks++; if (cycle_cnt !== 32'd20) begin n_fail++; $display("FAIL sat_wide got=%0d exp=20", cycle_cnt); end
    cyc(0, 0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_run();
    test_step();
`ifdef CPU_RUN_CTRL_BP_EN
    test_breakpoint();
    test_simultaneous();
`else
    test_no_break();
`endif
    test_halt();
    test_reset_mid_run();
    test_saturate();
    n_checks++;
    if (ce_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d exp=0", ce_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
